jtcontra_obj_romrq: RTL and testbench
=====================================

JTCONTRA_OBJ_ROMRQ -- requirements
Module: jtcontra_obj_romrq

Interface
REQ-001 SHALL have parameter OFFSET, default 22'h0, meaning the SDRAM 16-bit-word base address of the object ROM region.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rom_cs  input  1  object-engine fetch request, level.
REQ-005 SHALL have port rom_addr  input  18  object ROM 16-bit-word address {code, vsub, h4}.
REQ-006 SHALL have port rom_ok  output  1  rom_data is valid for the rom_addr presented one cycle earlier.
REQ-007 SHALL have port rom_data  output  16  object pixel word.
REQ-008 SHALL have port sdram_req  output  1  SDRAM slot request, level.
REQ-009 SHALL have port sdram_addr  output  22  SDRAM 16-bit-word address of a 2-word burst.
REQ-010 SHALL have port sdram_ack  input  1  one-cycle pulse; controller accepted the request.
REQ-011 SHALL have port data_rdy  input  1  one-cycle pulse; data_read valid.
REQ-012 SHALL have port data_read  input  32  burst data; [15:0] is the even word, [31:16] the odd word.

Function
REQ-013 SHALL hold a cache of entries, each: valid, tag = addr[17:1] (17 bits), data (32 bits).
REQ-014 SHALL signal a hit when rom_cs=1 and any valid entry's tag equals rom_addr[17:1].
REQ-015 SHALL register rom_ok and rom_data: on a hit sampled at edge N, rom_ok=1 after edge N and rom_data = rom_addr[0] ? data[31:16] : data[15:0]; 1-cycle hit latency.
REQ-016 SHALL drive rom_ok=0 on any cycle whose previous-edge sample was a miss or had rom_cs=0; rom_data holds its last value.
REQ-017 SHALL use FSM IDLE, REQ, WAIT, FILL.
REQ-018 IDLE: on a miss with rom_cs=1, latch tag, set sdram_addr = OFFSET + {rom_addr[17:1], 1'b0} (mod 2^22), raise sdram_req, go REQ.
REQ-019 REQ: hold sdram_req and sdram_addr until sdram_ack; on ack drop sdram_req, go WAIT; if ack and data_rdy coincide, go straight to FILL with that data.
REQ-020 WAIT: on data_rdy capture data_read, go FILL.
REQ-021 FILL: write the latched tag and data into the victim entry, set valid, go IDLE; the hit is evaluated on the following edge, so a miss costs fill latency plus 2 cycles.
REQ-022 SHALL complete an in-flight fetch and fill the entry even if rom_cs drops or rom_addr changes; rom_ok stays 0 until a fresh hit.
REQ-023 SHALL ignore sdram_ack and data_rdy while in IDLE or FILL.
REQ-024 SHALL never issue a second request while REQ, WAIT or FILL is active.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear all valid bits, rom_ok=0, rom_data=0, sdram_req=0, sdram_addr=0, victim pointer=0, and state=IDLE; a reset mid-fetch abandons it, and late ack/data_rdy are ignored per REQ-023.

Configuration
REQ-026 With JTCONTRA_OBJROM_2WAY_EN defined, SHALL have 2 entries, a hit on either, and a victim pointer that toggles after each FILL.
REQ-027 Without JTCONTRA_OBJROM_2WAY_EN, SHALL have exactly 1 entry, always the victim; ports and latency are unchanged.

Structure
REQ-028 SHALL take FSM state encoding, TAG_W=17, DATA_W=32 and SDRAM_AW=22 from shared package jtcontra_obj_pkg.
REQ-029 SHALL place the per-entry tag/data/valid storage and hit compare in sub-module jtcontra_objrom_entry, instantiated once or twice.

Verification
REQ-030 Cold miss: rom_cs=1, rom_addr=18'h00011, OFFSET=22'h10_0000 -> sdram_req=1, sdram_addr=22'h10_0010 held until ack; data_read=32'hBEEF_CAFE -> rom_ok=1 with rom_data=16'hBEEF 2 cycles after data_rdy.
REQ-031 Pair hit: after REQ-030, rom_addr=18'h00010 -> no sdram_req; rom_ok=1 and rom_data=16'hCAFE on the next cycle.
REQ-032 2-way: fill tag 0x00008 then 0x00010; alternate both -> zero further requests; a third tag evicts entry 0 (the first filled); no macro -> every tag change requests.
REQ-033 Abort: drop rom_cs in WAIT -> fill completes, rom_ok stays 0; re-raise rom_cs on the same address -> hit in 1 cycle.
REQ-034 Reset mid-WAIT: rst_n low 1 cycle -> sdram_req=0, rom_ok=0; stray data_rdy afterwards -> no fill; the same address then misses again.
REQ-035 Coincident ack+data_rdy in REQ -> data captured, FILL next, rom_ok 2 cycles later.

Source files
------------

// File: rtl/jtcontra_obj_pkg.sv
// jtcontra_obj_pkg: shared widths, FSM encoding and way count for the object ROM requester
//   Build option: JTCONTRA_OBJROM_2WAY_EN selects a 2-entry cache (default 1 entry)
package jtcontra_obj_pkg;
  localparam int TAG_W = 17;
  localparam int DATA_W = 32;
  localparam int SDRAM_AW = 22;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_FILL = 2'd3;
`ifdef JTCONTRA_OBJROM_2WAY_EN
  localparam int NWAY = 2;
`else
  localparam int NWAY = 1;
`endif
endpackage

// File: rtl/jtcontra_obj_romrq_if.sv
// jtcontra_obj_romrq_if: object-engine fetch port plus SDRAM slot port
//   rom_cs/rom_addr -> rom_ok/rom_data : object engine side
//   sdram_req/sdram_addr -> sdram_ack/data_rdy/data_read : SDRAM controller side
//   slave = requester, master = engine + controller (or testbench)
interface jtcontra_obj_romrq_if;
  import jtcontra_obj_pkg::*;
  logic rom_cs;
  logic [17:0] rom_addr;
  logic rom_ok;
  logic [15:0] rom_data;
  logic sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic sdram_ack;
  logic data_rdy;
  logic [DATA_W-1:0] data_read;
  modport slave(input rom_cs, rom_addr, sdram_ack, data_rdy, data_read,
                output rom_ok, rom_data, sdram_req, sdram_addr);
  modport master(output rom_cs, rom_addr, sdram_ack, data_rdy, data_read,
                 input rom_ok, rom_data, sdram_req, sdram_addr);
endinterface

// File: rtl/jtcontra_objrom_entry.sv
// jtcontra_objrom_entry: one cache line (valid, tag, 32-bit burst) with hit compare
//   i_we writes i_tag/i_data and sets valid; o_hit = valid && tag == i_look
module jtcontra_objrom_entry
  import jtcontra_obj_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_look,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);
  logic r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag <= '0;
      r_data <= '0;
    end else if (i_we) begin
      r_valid <= 1'b1;
      r_tag <= i_tag;
      r_data <= i_data;
    end
  end
  assign o_hit = r_valid && (r_tag == i_look);
  assign o_data = r_data;
endmodule

// File: rtl/jtcontra_obj_romrq.sv
// jtcontra_obj_romrq: object ROM word cache that fetches 2-word SDRAM bursts on a miss
//   clk, rst_n (async active-low); bus: jtcontra_obj_romrq_if.slave
//   Build option: JTCONTRA_OBJROM_2WAY_EN gives two entries with a toggling victim
module jtcontra_obj_romrq
  import jtcontra_obj_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
  input logic clk,
  input logic rst_n,
  jtcontra_obj_romrq_if.slave bus
);
  logic [1:0] r_state;
  logic r_victim;
  logic [TAG_W-1:0] r_tag;
  logic [DATA_W-1:0] r_data;
  logic r_ok;
  logic [15:0] r_rdata;
  logic r_req;
  logic [SDRAM_AW-1:0] r_addr;
  logic [TAG_W-1:0] w_tag;
  logic [NWAY-1:0] w_hit;
  logic [DATA_W-1:0] w_data [NWAY];
  logic [DATA_W-1:0] w_sel;
  logic w_any;
  assign w_tag = bus.rom_addr[17:1];
  for (genvar i = 0; i < NWAY; i++) begin : g_way
    jtcontra_objrom_entry u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  ((r_state == ST_FILL) && (r_victim == 1'(i))),
      .i_tag (r_tag),
      .i_data(r_data),
      .i_look(w_tag),
      .o_hit (w_hit[i]),
      .o_data(w_data[i])
    );
  end
  assign w_any = bus.rom_cs && |w_hit;
  assign w_sel = w_hit[0] ? w_data[0] : w_data[NWAY-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_victim <= 1'b0;
      r_tag <= '0;
      r_data <= '0;
      r_ok <= 1'b0;
      r_rdata <= '0;
      r_req <= 1'b0;
      r_addr <= '0;
    end else begin
      r_ok <= w_any;
      if (w_any) r_rdata <= bus.rom_addr[0] ? w_sel[31:16] : w_sel[15:0];
      case (r_state)
        ST_IDLE: if (bus.rom_cs && !w_any) begin
          r_tag <= w_tag;
          r_addr <= OFFSET + {4'b0, w_tag, 1'b0};
          r_req <= 1'b1;
          r_state <= ST_REQ;
        end
        ST_REQ: if (bus.sdram_ack) begin
          r_req <= 1'b0;
          if (bus.data_rdy) r_data <= bus.data_read;
          r_state <= bus.data_rdy ? ST_FILL : ST_WAIT;
        end
        ST_WAIT: if (bus.data_rdy) begin
          r_data <= bus.data_read;
          r_state <= ST_FILL;
        end
        default: begin
`ifdef JTCONTRA_OBJROM_2WAY_EN
          r_victim <= ~r_victim;
`else
          r_victim <= 1'b0;
`endif
          r_state <= ST_IDLE;
        end
      endcase
    end
  end
  assign bus.rom_ok = r_ok;
  assign bus.rom_data = r_rdata;
  assign bus.sdram_req = r_req;
  assign bus.sdram_addr = r_addr;
endmodule

// File: tb/tb_jtcontra_obj_romrq.sv
// tb_jtcontra_obj_romrq: scoreboard bench for the object ROM requester (follows JTCONTRA_OBJROM_2WAY_EN)
module tb_jtcontra_obj_romrq;
  localparam logic [21:0] OFS = 22'h10_0000;
`ifdef JTCONTRA_OBJROM_2WAY_EN
  localparam int NW = 2;
`else
  localparam int NW = 1;
`endif
  typedef struct {
    int cyc;
    logic [15:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] last = 16'h0;
  exp_t sbq[$];
  logic [16:0] m_tag[2];
  bit m_val[2];
  int m_vic = 0;
  jtcontra_obj_romrq_if bus ();
  jtcontra_obj_romrq #(.OFFSET(OFS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask
  function automatic logic [21:0] sadr(input logic [17:0] a);
    return OFS + {4'b0, a[17:1], 1'b0};
  endfunction
  function automatic logic [31:0] mem(input logic [21:0] sa);
    return sa == 22'h10_0010 ? 32'hBEEF_CAFE : {sa[15:0] ^ 16'h5A5A, ~sa[15:0]};
  endfunction
  function automatic logic [15:0] word(input logic [17:0] a);
    logic [31:0] m;
    m = mem(sadr(a));
    return a[0] ? m[31:16] : m[15:0];
  endfunction
  function automatic bit m_hit(input logic [17:0] a);
    bit h = 0;
    for (int i = 0; i < NW; i++) if (m_val[i] && m_tag[i] == a[17:1]) h = 1;
    return h;
  endfunction
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      chk("hit_ok", bus.rom_ok, 1);
      chk("hit_data", bus.rom_data, sbq[0].d);
      last = sbq[0].d;
      void'(sbq.pop_front());
    end else begin
      chk("ok_low", bus.rom_ok, 0);
      chk("data_hold", bus.rom_data, last);
    end
  end
  task automatic present(input logic [17:0] a);
    exp_t e;
    bus.rom_cs = 1'b1;
    bus.rom_addr = a;
    e.cyc = cyc + 1;
    e.d = word(a);
    sbq.push_back(e);
    @(negedge clk);
    chk("hit_noreq", bus.sdram_req, 0);
  endtask
  task automatic miss(input logic [17:0] a, input int ack_dly, input int rdy_dly,
                      input bit drop_cs, input bit rst_wait);
    logic [21:0] sa;
    sa = sadr(a);
    bus.rom_cs = 1'b1;
    bus.rom_addr = a;
    @(negedge clk);
    chk("req_on", bus.sdram_req, 1);
    chk("req_addr", bus.sdram_addr, 32'(sa));
    repeat (ack_dly) begin
      @(negedge clk);
      chk("req_hold", {bus.sdram_req, bus.sdram_addr}, {9'h0, 1'b1, sa});
    end
    bus.sdram_ack = 1'b1;
    if (rdy_dly == 0) begin
      bus.data_rdy = 1'b1;
      bus.data_read = mem(sa);
    end
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.data_rdy = 1'b0;
    chk("req_drop", bus.sdram_req, 0);
    if (drop_cs) bus.rom_cs = 1'b0;
    if (rst_wait) begin
      bus.rom_cs = 1'b0;
      rst_n = 1'b0;
      last = 16'h0;
      m_val[0] = 0;
      m_val[1] = 0;
      m_vic = 0;
      #1;
      chk("rst_req", bus.sdram_req, 0);
      chk("rst_ok", bus.rom_ok, 0);
      chk("rst_addr", bus.sdram_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.data_rdy = 1'b1;
      bus.data_read = mem(sa);
      @(negedge clk);
      bus.data_rdy = 1'b0;
      @(negedge clk);
      chk("stray_noreq", bus.sdram_req, 0);
      return;
    end
    if (rdy_dly > 0) begin
      repeat (rdy_dly - 1) begin
        @(negedge clk);
        chk("wait_noreq", bus.sdram_req, 0);
      end
      bus.data_rdy = 1'b1;
      bus.data_read = mem(sa);
      @(negedge clk);
      bus.data_rdy = 1'b0;
    end
    m_tag[m_vic] = a[17:1];
    m_val[m_vic] = 1;
    m_vic = (NW == 2) ? 1 - m_vic : 0;
    @(negedge clk);
    chk("fill_noreq", bus.sdram_req, 0);
  endtask
  task automatic access(input logic [17:0] a, input int ack_dly, input int rdy_dly);
    if (!m_hit(a)) miss(a, ack_dly, rdy_dly, 0, 0);
    present(a);
  endtask
  initial begin
    bus.rom_cs = 1'b0;
    bus.rom_addr = '0;
    bus.sdram_ack = 1'b0;
    bus.data_rdy = 1'b0;
    bus.data_read = '0;
    repeat (2) @(negedge clk);
    chk("rst_ok0", bus.rom_ok, 0);
    chk("rst_data0", bus.rom_data, 0);
    chk("rst_req0", bus.sdram_req, 0);
    chk("rst_addr0", bus.sdram_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    access(18'h00011, 2, 3);
    present(18'h00010);
    access(18'h00020, 1, 2);
    access(18'h00010, 0, 1);
    access(18'h00021, 1, 1);
    access(18'h00011, 0, 2);
    access(18'h00020, 2, 1);
    access(18'h00030, 1, 1);
    access(18'h00020, 1, 1);
    access(18'h00011, 0, 1);
    miss(18'h00040, 1, 3, 1, 0);
    repeat (2) @(negedge clk);
    present(18'h00040);
    present(18'h00041);
    miss(18'h00051, 1, 0, 0, 0);
    present(18'h00051);
    bus.rom_cs = 1'b0;
    repeat (2) @(negedge clk);
    bus.sdram_ack = 1'b1;
    bus.data_rdy = 1'b1;
    bus.data_read = 32'hDEAD_0000;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.data_rdy = 1'b0;
    @(negedge clk);
    chk("idle_ignore", bus.sdram_req, 0);
    present(18'h00050);
    miss(18'h00060, 1, 2, 0, 1);
    access(18'h00060, 1, 2);
    access(18'h00051, 0, 0);
    bus.rom_cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
